// File: rtl/pipeline_multiplier_pkg.sv
// Shared width constants for the restoring divider and its inverse multiplier.
// Both blocks import this package so that they always agree on operand widths.
//   QW      quotient width, also the number of pipeline stages
//   DW      divisor / addend width
//   PW      product width (QW + DW), derived and not overridable
//   NSTAGES pipeline depth
package pipeline_multiplier_pkg;

    localparam int QW      = 8;
    localparam int DW      = 20;
    localparam int PW      = QW + DW;
    localparam int NSTAGES = QW;

endpackage

// File: rtl/pipeline_multiplier_stage.sv
// One shift-and-add step of the pipelined multiplier, consuming one quotient
// bit (MSB first) per clock.
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   start                   valid bit entering this stage
//   acc_in [PW]             partial sum from the previous stage
//   divisor, addend [DW]    operands carried alongside the data
//   q_in [QW]               remaining quotient bits; bit QW-1 is used here
//   start_out               registered valid
//   acc_out [PW]            (acc_in << 1) + (q_in[QW-1] ? divisor : 0)
//   divisor_out, addend_out operands passed through unchanged
//   q_out [QW]              q_in shifted left by one
module multiplier_pipe_stage
    import pipeline_multiplier_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [PW-1:0] acc_in,
    input  logic [DW-1:0] divisor,
    input  logic [DW-1:0] addend,
    input  logic [QW-1:0] q_in,
    output logic          start_out,
    output logic [PW-1:0] acc_out,
    output logic [DW-1:0] divisor_out,
    output logic [DW-1:0] addend_out,
    output logic [QW-1:0] q_out
);

    logic [PW-1:0] partial;

    assign partial = q_in[QW-1] ? PW'(divisor) : '0;

    // Data registers load every cycle regardless of valid; bubbles carry
    // don't-care data and only the valid bit decides whether it is used.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_out   <= 1'b0;
            acc_out     <= '0;
            divisor_out <= '0;
            addend_out  <= '0;
            q_out       <= '0;
        end else begin
            start_out   <= start;
            acc_out     <= (acc_in << 1) + partial;
            divisor_out <= divisor;
            addend_out  <= addend;
            q_out       <= q_in << 1;
        end
    end

endmodule

// File: rtl/pipeline_multiplier.sv
// Fixed-latency (8 clocks), fully pipelined multiply-accumulate:
//   product = q * divisor + addend
// Rebuilds the dividend from the restoring divider's quotient and remainder,
// and doubles as a general 8x20 scaler. One operation per clock, no stall.
// Ports:
//   clock     rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     qualifies q/divisor/addend this cycle
//   q         multiplier operand (quotient), 8 bits
//   divisor   multiplicand, 20 bits
//   addend    added to the final sum (remainder), 20 bits
//   product   28-bit result, held between results
//   StartOut  one-cycle pulse marking a new product
module pipeline_multiplier
    import pipeline_multiplier_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [QW-1:0] q,
    input  logic [DW-1:0] divisor,
    input  logic [DW-1:0] addend,
    output logic [PW-1:0] product,
    output logic          StartOut
);

    // Index 0 is the module input; index k+1 is the output of stage k.
    logic          vld_c [0:NSTAGES-1];
    logic [PW-1:0] acc_c [0:NSTAGES-1];
    logic [DW-1:0] div_c [0:NSTAGES-1];
    logic [DW-1:0] add_c [0:NSTAGES-1];
    logic [QW-1:0] q_c   [0:NSTAGES-1];

    assign vld_c[0] = start;
    assign acc_c[0] = '0;
    assign div_c[0] = divisor;
    assign add_c[0] = addend;
    assign q_c[0]   = q;

    for (genvar k = 0; k < NSTAGES - 1; k++) begin : g_stage
        multiplier_pipe_stage u_stage (
            .clock       (clock),
            .reset_n     (reset_n),
            .start       (vld_c[k]),
            .acc_in      (acc_c[k]),
            .divisor     (div_c[k]),
            .addend      (add_c[k]),
            .q_in        (q_c[k]),
            .start_out   (vld_c[k+1]),
            .acc_out     (acc_c[k+1]),
            .divisor_out (div_c[k+1]),
            .addend_out  (add_c[k+1]),
            .q_out       (q_c[k+1])
        );
    end

    // After NSTAGES-1 left shifts only the original q[0] can still be set
    // (the low bits are shifted-in zeros, also zero out of reset), so the
    // OR-reduction equals that last bit.
    logic          last_bit;
    logic [PW-1:0] last_partial;
    logic [PW-1:0] final_sum;

    assign last_bit     = |q_c[NSTAGES-1];
    assign last_partial = last_bit ? PW'(div_c[NSTAGES-1]) : '0;
    assign final_sum    = (acc_c[NSTAGES-1] << 1) + last_partial
                          + PW'(add_c[NSTAGES-1]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            product  <= '0;
            StartOut <= 1'b0;
        end else begin
            StartOut <= vld_c[NSTAGES-1];
            if (vld_c[NSTAGES-1]) begin
                product <= final_sum;
            end
        end
    end

endmodule
